// File: rtl/traffic_monitor.sv
// traffic_monitor
//   Passive checker that watches a two-road traffic-light controller and
//   latches sticky error flags when the lights, their dwell times or the
//   pedestrian signals misbehave. One clock tick is one second.
//
//   Optional feature macro: MONITOR_DWELL_CHECK_EN
//     defined   : per-road dwell counters and GREEN/YELLOW dwell checks exist
//     undefined : no dwell counters; err_dwell is constant 0
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   reset          in   asynchronous, active-low reset
//   T1state/T2state in  2-bit light per road: 00 RED, 01 GREEN, 10 YELLOW, 11 illegal
//   T1_WALK/T2_WALK in  pedestrian walk across road 1 / road 2
//   buzzer_walk    in   audible walk indicator, must equal T1_WALK | T2_WALK
//   err_clr        in   synchronous clear of the sticky flags and the count
//   err_conflict   out  sticky: both roads non-RED
//   err_encoding   out  sticky: 11 seen on a state input
//   err_transition out  sticky: illegal light sequence
//   err_dwell      out  sticky: GREEN/YELLOW dwell out of range
//   err_walk       out  sticky: walk/buzzer rule broken
//   err_any        out  OR of the five sticky flags
//   err_count      out  8-bit saturating count of cycles with a new violation
module traffic_monitor #(
  parameter int YEL_MIN   = 3,
  parameter int YEL_MAX   = 5,
  parameter int MIN_GREEN = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] T1state,
  input  logic [1:0] T2state,
  input  logic       T1_WALK,
  input  logic       T2_WALK,
  input  logic       buzzer_walk,
  input  logic       err_clr,
  output logic       err_conflict,
  output logic       err_encoding,
  output logic       err_transition,
  output logic       err_dwell,
  output logic       err_walk,
  output logic       err_any,
  output logic [7:0] err_count
);

  localparam int          NUM_ROADS = 2;
  localparam logic [1:0]  RED = 2'b00;
  localparam logic [1:0]  GRN = 2'b01;
  localparam logic [1:0]  YEL = 2'b10;
  localparam logic [1:0]  ILL = 2'b11;

  // flag bit positions in r_flags / w_new
  localparam int F_CONF = 4;
  localparam int F_ENC  = 3;
  localparam int F_TRN  = 2;
  localparam int F_DWL  = 1;
  localparam int F_WLK  = 0;

  logic [NUM_ROADS-1:0][1:0] w_st;
  logic [NUM_ROADS-1:0]      w_walk;
  logic [NUM_ROADS-1:0][1:0] r_prev;
  logic                      r_prev_vld;

  logic [NUM_ROADS-1:0] w_enc;   // road sample is 11
  logic [NUM_ROADS-1:0] w_chg;   // road sample differs from previous sample
  logic [NUM_ROADS-1:0] w_hist;  // usable history: previous sample valid and legal
  logic [NUM_ROADS-1:0] w_trn;
  logic [NUM_ROADS-1:0] w_wlk;
  logic                 w_conf;
  logic                 w_buzz;
  logic                 w_dwl_any;
  logic [4:0]           w_new;
  logic                 w_viol;

  logic [4:0]           r_flags;
  logic [7:0]           r_cnt;

  assign w_st   = {T2state, T1state};
  assign w_walk = {T2_WALK, T1_WALK};

  always_comb begin
    w_enc  = '0;
    w_chg  = '0;
    w_hist = '0;
    w_trn  = '0;
    w_wlk  = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      w_enc[i]  = (w_st[i] == ILL);
      w_chg[i]  = (w_st[i] != r_prev[i]);
      // An 11 sample (now or previously) gives no meaningful sequence, so the
      // road's sequence checks are suppressed around it.
      w_hist[i] = r_prev_vld && (r_prev[i] != ILL) && !w_enc[i];
      w_trn[i]  = w_hist[i] &&
                  (((r_prev[i] == GRN) && (w_st[i] == RED)) ||
                   ((r_prev[i] == RED) && (w_st[i] == YEL)) ||
                   ((r_prev[i] == YEL) && (w_st[i] == GRN)));
      w_wlk[i]  = w_walk[i] && !w_enc[i] && (w_st[i] != RED);
    end
  end

  // 11 counts as non-RED for the conflict check.
  assign w_conf = (T1state != RED) && (T2state != RED);
  assign w_buzz = buzzer_walk != (T1_WALK | T2_WALK);

`ifdef MONITOR_DWELL_CHECK_EN
  localparam logic [7:0] L_YMIN = 8'(YEL_MIN);
  localparam logic [7:0] L_YMAX = 8'(YEL_MAX);
  localparam logic [7:0] L_GMIN = 8'(MIN_GREEN);

  // r_dwell holds the dwell of the most recent sample, counting from 1.
  logic [7:0]           r_dwell [NUM_ROADS];
  logic [NUM_ROADS-1:0] w_dwl;

  always_comb begin
    w_dwl = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      // Exit checks use the dwell of the state being left (still in r_dwell).
      // Overstay fires once: on the edge the count would step from YEL_MAX
      // to YEL_MAX+1; later YELLOW samples never match again.
      w_dwl[i] = (w_hist[i] && w_chg[i] && (r_prev[i] == YEL) && (r_dwell[i] < L_YMIN)) ||
                 (w_hist[i] && w_chg[i] && (r_prev[i] == GRN) && (r_dwell[i] < L_GMIN)) ||
                 (w_hist[i] && !w_chg[i] && (w_st[i] == YEL) && (r_dwell[i] == L_YMAX));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ROADS; i++) r_dwell[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_ROADS; i++) begin
        if (!r_prev_vld || w_chg[i])  r_dwell[i] <= 8'd1;
        else if (r_dwell[i] != 8'hFF) r_dwell[i] <= r_dwell[i] + 8'd1;
      end
    end
  end

  assign w_dwl_any = |w_dwl;
`else
  assign w_dwl_any = 1'b0;
`endif

  always_comb begin
    w_new         = '0;
    w_new[F_CONF] = w_conf;
    w_new[F_ENC]  = |w_enc;
    w_new[F_TRN]  = |w_trn;
    w_new[F_DWL]  = w_dwl_any;
    w_new[F_WLK]  = (|w_wlk) || w_buzz;
  end

  assign w_viol = |w_new;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_flags    <= '0;
      r_cnt      <= 8'd0;
    end else begin
      r_prev     <= w_st;
      r_prev_vld <= 1'b1;
      // A violation in the clear cycle survives the clear.
      r_flags    <= err_clr ? w_new : (r_flags | w_new);
      if (err_clr)                      r_cnt <= w_viol ? 8'd1 : 8'd0;
      else if (w_viol && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign err_conflict   = r_flags[F_CONF];
  assign err_encoding   = r_flags[F_ENC];
  assign err_transition = r_flags[F_TRN];
  assign err_dwell      = r_flags[F_DWL];
  assign err_walk       = r_flags[F_WLK];
  assign err_any        = |r_flags;
  assign err_count      = r_cnt;

endmodule
